bp_be_ptw_miss_arbiter: RTL and testbench

// Schedules TLB-miss walks onto the single page-table walker for two requesters: instruction side
// (ITLB miss) and data side (DTLB load/store miss). Buffers one miss per requester, grants walks

---
 rtl/bp_be_ptw_miss_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bp_be_ptw_miss_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_ptw_miss_arbiter.sv
// bp_be_ptw_miss_arbiter
//   Schedules ITLB and DTLB miss walks onto a single page-table walker.
//   Each side has a one-entry miss buffer. Walks are granted round-robin,
//   with only one walk in flight at a time. The fill or page fault is
//   routed back to the side that issued the walk.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   flush_i                 drops buffered misses and abandons the current walk
//   instr_miss_v_i/vaddr_i  ITLB miss in; instr_ready_o = instruction buffer empty
//   data_miss_v_i/store_i/vaddr_i  DTLB miss in; data_ready_o = data buffer empty
//   walk_*                  walk request to the PTW (valid/ready handshake)
//   fill_v_i/fault_i/ptag_i walk completion from the PTW
//   itlb/dtlb_fill_v_o, fill_ptag_o   TLB write, one cycle
//   *_page_fault_v_o, fault_vaddr_o   page fault report, one cycle
//   busy_o                  a walk is active or a buffer is occupied
module bp_be_ptw_miss_arbiter #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,

    input  logic                     instr_miss_v_i,
    input  logic [vaddr_width_p-1:0] instr_vaddr_i,
    output logic                     instr_ready_o,

    input  logic                     data_miss_v_i,
    input  logic                     data_store_i,
    input  logic [vaddr_width_p-1:0] data_vaddr_i,
    output logic                     data_ready_o,

    output logic                     walk_v_o,
    input  logic                     walk_ready_i,
    output logic                     walk_instr_o,
    output logic                     walk_store_o,
    output logic [vaddr_width_p-1:0] walk_vaddr_o,

    input  logic                     fill_v_i,
    input  logic                     fill_fault_i,
    input  logic [ptag_width_p-1:0]  fill_ptag_i,

    output logic                     itlb_fill_v_o,
    output logic                     dtlb_fill_v_o,
    output logic [ptag_width_p-1:0]  fill_ptag_o,
    output logic                     instr_page_fault_v_o,
    output logic                     load_page_fault_v_o,
    output logic                     store_page_fault_v_o,
    output logic [vaddr_width_p-1:0] fault_vaddr_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                   state_q;

    logic                     ibuf_v_q;
    logic [vaddr_width_p-1:0] ibuf_vaddr_q;
    logic                     dbuf_v_q;
    logic                     dbuf_store_q;
    logic [vaddr_width_p-1:0] dbuf_vaddr_q;

    // 0: instruction side has priority when both buffers are full, 1: data side
    logic                     rr_data_q;

    logic                     walk_instr_q;
    logic                     walk_store_q;
    logic [vaddr_width_p-1:0] walk_vaddr_q;

    logic sel_instr;
    logic walk_accept;
    logic resp_v;

    // Instruction wins if it is the only full buffer, or if both are full and
    // the pointer favours it.
    assign sel_instr   = ibuf_v_q & (~dbuf_v_q | ~rr_data_q);
    assign walk_accept = (state_q == REQ) & walk_ready_i;
    assign resp_v      = (state_q == WAIT) & fill_v_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            ibuf_v_q     <= 1'b0;
            ibuf_vaddr_q <= '0;
            dbuf_v_q     <= 1'b0;
            dbuf_store_q <= 1'b0;
            dbuf_vaddr_q <= '0;
            rr_data_q    <= 1'b0;
            walk_instr_q <= 1'b0;
            walk_store_q <= 1'b0;
            walk_vaddr_q <= '0;
        end else begin
            // Miss buffers. A buffer is freed only when its walk is accepted.
            // Ready is the registered empty flag, so a freed buffer cannot take
            // a new miss until the following cycle.
            if (flush_i) begin
                ibuf_v_q <= 1'b0;
                dbuf_v_q <= 1'b0;
            end else begin
                if (walk_accept & walk_instr_q) begin
                    ibuf_v_q <= 1'b0;
                end else if (instr_miss_v_i & ~ibuf_v_q) begin
                    ibuf_v_q     <= 1'b1;
                    ibuf_vaddr_q <= instr_vaddr_i;
                end
                if (walk_accept & ~walk_instr_q) begin
                    dbuf_v_q <= 1'b0;
                end else if (data_miss_v_i & ~dbuf_v_q) begin
                    dbuf_v_q     <= 1'b1;
                    dbuf_store_q <= data_store_i;
                    dbuf_vaddr_q <= data_vaddr_i;
                end
            end

            unique case (state_q)
                IDLE: begin
                    // A flush empties the buffers this cycle, so nothing to grant.
                    if (~flush_i & (ibuf_v_q | dbuf_v_q)) begin
                        walk_instr_q <= sel_instr;
                        walk_store_q <= sel_instr ? 1'b0 : dbuf_store_q;
                        walk_vaddr_q <= sel_instr ? ibuf_vaddr_q : dbuf_vaddr_q;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (walk_ready_i) begin
                        rr_data_q <= walk_instr_q;
                        // Walk already handed to the PTW; a flush must still
                        // swallow its fill.
                        state_q   <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        state_q   <= IDLE;
                    end
                end
                WAIT: begin
                    // A fill that coincides with a flush completes the walk;
                    // going to DRAIN would wait for a fill that never comes.
                    if (fill_v_i)     state_q <= IDLE;
                    else if (flush_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (fill_v_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready_o = ~ibuf_v_q;
    assign data_ready_o  = ~dbuf_v_q;

    assign walk_v_o     = (state_q == REQ);
    assign walk_instr_o = walk_instr_q;
    assign walk_store_o = walk_store_q;
    assign walk_vaddr_o = walk_vaddr_q;

    // Responses come straight from the fill pulse so the TLB write lands
    // in the same cycle the PTW completes.
    assign itlb_fill_v_o        = resp_v & ~fill_fault_i &  walk_instr_q;
    assign dtlb_fill_v_o        = resp_v & ~fill_fault_i & ~walk_instr_q;
    assign instr_page_fault_v_o = resp_v &  fill_fault_i &  walk_instr_q;
    assign load_page_fault_v_o  = resp_v &  fill_fault_i & ~walk_instr_q & ~walk_store_q;
    assign store_page_fault_v_o = resp_v &  fill_fault_i & ~walk_instr_q &  walk_store_q;
    assign fill_ptag_o          = fill_ptag_i;
    assign fault_vaddr_o        = walk_vaddr_q;

    assign busy_o = (state_q != IDLE) | ibuf_v_q | dbuf_v_q;

endmodule

// File: tb/tb_bp_be_ptw_miss_arbiter.sv
module tb_bp_be_ptw_miss_arbiter;
  localparam int VW = 39;
  localparam int PW = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, flush_i;
  logic          instr_miss_v_i, instr_ready_o;
  logic [VW-1:0] instr_vaddr_i;
  logic          data_miss_v_i, data_store_i, data_ready_o;
  logic [VW-1:0] data_vaddr_i;
  logic          walk_v_o, walk_ready_i, walk_instr_o, walk_store_o;
  logic [VW-1:0] walk_vaddr_o;
  logic          fill_v_i, fill_fault_i;
  logic [PW-1:0] fill_ptag_i, fill_ptag_o;
  logic          itlb_fill_v_o, dtlb_fill_v_o;
  logic          instr_page_fault_v_o, load_page_fault_v_o, store_page_fault_v_o;
  logic [VW-1:0] fault_vaddr_o;
  logic          busy_o;

  bp_be_ptw_miss_arbiter #(.vaddr_width_p(VW), .ptag_width_p(PW)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .instr_miss_v_i(instr_miss_v_i), .instr_vaddr_i(instr_vaddr_i), .instr_ready_o(instr_ready_o),
    .data_miss_v_i(data_miss_v_i), .data_store_i(data_store_i), .data_vaddr_i(data_vaddr_i),
    .data_ready_o(data_ready_o),
    .walk_v_o(walk_v_o), .walk_ready_i(walk_ready_i), .walk_instr_o(walk_instr_o),
    .walk_store_o(walk_store_o), .walk_vaddr_o(walk_vaddr_o),
    .fill_v_i(fill_v_i), .fill_fault_i(fill_fault_i), .fill_ptag_i(fill_ptag_i),
    .itlb_fill_v_o(itlb_fill_v_o), .dtlb_fill_v_o(dtlb_fill_v_o), .fill_ptag_o(fill_ptag_o),
    .instr_page_fault_v_o(instr_page_fault_v_o), .load_page_fault_v_o(load_page_fault_v_o),
    .store_page_fault_v_o(store_page_fault_v_o), .fault_vaddr_o(fault_vaddr_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending misses per side, plus the one walk the PTW owns.
  // Walk life cycle: none -> offered -> outstanding (answer) / abandoned (swallow).
  typedef struct packed {
    logic          v;
    logic          instr;
    logic          store;
    logic [VW-1:0] va;
  } miss_t;

  typedef enum int {W_NONE, W_OFFERED, W_OUTSTANDING, W_ABANDONED} walk_e;

  miss_t m_ib, m_db, m_cur;
  walk_e m_walk;
  logic  m_next_data;   // which side goes first when both are pending
  logic  m_live = 1'b0;

  always @(posedge clk) begin
    if (reset_i) begin
      m_ib <= '0; m_db <= '0; m_cur <= '0;
      m_walk <= W_NONE; m_next_data <= 1'b0; m_live <= 1'b1;
    end else if (m_live) begin
      miss_t nib, ndb;
      nib = m_ib; ndb = m_db;
      if (m_walk == W_OFFERED && walk_ready_i) begin
        if (m_cur.instr) nib.v = 1'b0; else ndb.v = 1'b0;
        m_next_data <= m_cur.instr;
      end
      if (!m_ib.v && instr_miss_v_i) nib = '{1'b1, 1'b1, 1'b0, instr_vaddr_i};
      if (!m_db.v && data_miss_v_i)  ndb = '{1'b1, 1'b0, data_store_i, data_vaddr_i};
      if (flush_i) begin nib.v = 1'b0; ndb.v = 1'b0; end
      m_ib <= nib; m_db <= ndb;

      case (m_walk)
        W_NONE:
          if (!flush_i && (m_ib.v || m_db.v)) begin
            m_cur  <= (m_ib.v && m_db.v) ? (m_next_data ? m_db : m_ib) : (m_ib.v ? m_ib : m_db);
            m_walk <= W_OFFERED;
          end
        W_OFFERED:
          if (walk_ready_i) m_walk <= flush_i ? W_ABANDONED : W_OUTSTANDING;
          else if (flush_i) m_walk <= W_NONE;
        W_OUTSTANDING:
          if (fill_v_i) m_walk <= W_NONE;
          else if (flush_i) m_walk <= W_ABANDONED;
        W_ABANDONED:
          if (fill_v_i) m_walk <= W_NONE;
        default: m_walk <= W_NONE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      logic resp;
      resp = (m_walk == W_OUTSTANDING) && fill_v_i;
      chk("instr_ready", instr_ready_o, !m_ib.v);
      chk("data_ready",  data_ready_o,  !m_db.v);
      chk("walk_v",      walk_v_o,      m_walk == W_OFFERED);
      if (m_walk == W_OFFERED) begin
        chk("walk_instr", walk_instr_o, m_cur.instr);
        chk("walk_store", walk_store_o, m_cur.store);
        chk("walk_vaddr", walk_vaddr_o, m_cur.va);
      end
      chk("itlb_fill", itlb_fill_v_o, resp && !fill_fault_i && m_cur.instr);
      chk("dtlb_fill", dtlb_fill_v_o, resp && !fill_fault_i && !m_cur.instr);
      chk("instr_pf",  instr_page_fault_v_o, resp && fill_fault_i && m_cur.instr);
      chk("load_pf",   load_page_fault_v_o,  resp && fill_fault_i && !m_cur.instr && !m_cur.store);
      chk("store_pf",  store_page_fault_v_o, resp && fill_fault_i && !m_cur.instr && m_cur.store);
      if (resp) begin
        chk("fill_ptag",   fill_ptag_o,   fill_ptag_i);
        chk("fault_vaddr", fault_vaddr_o, m_cur.va);
      end
      chk("busy", busy_o, m_walk != W_NONE || m_ib.v || m_db.v);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; instr_miss_v_i = 0; data_miss_v_i = 0; data_store_i = 0;
    fill_v_i = 0; fill_fault_i = 0; walk_ready_i = 1;
  endtask

  task automatic do_reset();
    reset_i = 1; idle_inputs(); cyc(); cyc(); reset_i = 0;
  endtask

  // From a cycle in which the walk is offered with walk_ready_i high:
  // accept, wait one cycle, then pulse the fill.
  task automatic complete(input logic f, input logic [PW-1:0] p);
    cyc(); cyc();
    fill_fault_i = f; fill_ptag_i = p; fill_v_i = 1;
    cyc();
    fill_v_i = 0; fill_fault_i = 0;
  endtask

  task automatic instr_miss(input logic [VW-1:0] va);
    instr_miss_v_i = 1; instr_vaddr_i = va; cyc(); instr_miss_v_i = 0;
  endtask

  task automatic data_miss(input logic st, input logic [VW-1:0] va);
    data_miss_v_i = 1; data_store_i = st; data_vaddr_i = va; cyc(); data_miss_v_i = 0;
  endtask

  initial begin
    instr_vaddr_i = '0; data_vaddr_i = '0; fill_ptag_i = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst walk_v", walk_v_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst instr_ready", instr_ready_o, 1);
    chk("rst data_ready", data_ready_o, 1);

    // Single ITLB miss, fill 0x123 five cycles after acceptance
    cyc();
    instr_miss(39'h0_8000_1000);
    cyc();
    @(negedge clk);
    chk("t1 walk_v", walk_v_o, 1);
    chk("t1 walk_instr", walk_instr_o, 1);
    chk("t1 walk_vaddr", walk_vaddr_o, 39'h0_8000_1000);
    cyc();
    repeat (4) cyc();
    fill_ptag_i = 28'h123; fill_v_i = 1;
    @(negedge clk);
    chk("t1 itlb_fill", itlb_fill_v_o, 1);
    chk("t1 dtlb_fill", dtlb_fill_v_o, 0);
    chk("t1 fill_ptag", fill_ptag_o, 28'h123);
    chk("t1 fault_vaddr", fault_vaddr_o, 39'h0_8000_1000);
    cyc(); fill_v_i = 0;
    @(negedge clk);
    chk("t1 itlb_fill_pulse", itlb_fill_v_o, 0);
    chk("t1 busy", busy_o, 0);

    // Simultaneous instr + store miss after reset: instruction first
    do_reset();
    instr_miss_v_i = 1; instr_vaddr_i = 39'h11000;
    data_store_i = 1;   data_vaddr_i  = 39'h22000;
    data_miss(1, 39'h22000);
    instr_miss_v_i = 0;
    cyc();
    @(negedge clk);
    chk("t2 first instr", walk_instr_o, 1);
    complete(0, 28'h1);
    cyc();
    @(negedge clk);
    chk("t2 second data", walk_instr_o, 0);
    chk("t2 second store", walk_store_o, 1);
    chk("t2 second vaddr", walk_vaddr_o, 39'h22000);
    complete(0, 28'h2);
    // lone instr walk, then another pair: data side is now first
    instr_miss(39'h33000); cyc();
    complete(0, 28'h3);
    instr_miss_v_i = 1; instr_vaddr_i = 39'h44000;
    data_miss(0, 39'h55000);
    instr_miss_v_i = 0;
    cyc();
    @(negedge clk);
    chk("t2 rr data first", walk_instr_o, 0);
    complete(0, 28'h4); cyc();
    complete(0, 28'h5);

    // Load miss ending in page fault
    data_miss(0, 39'h7_0000_0040); cyc(); cyc(); cyc();
    fill_fault_i = 1; fill_v_i = 1;
    @(negedge clk);
    chk("t3 load_pf", load_page_fault_v_o, 1);
    chk("t3 dtlb_fill", dtlb_fill_v_o, 0);
    chk("t3 store_pf", store_page_fault_v_o, 0);
    chk("t3 instr_pf", instr_page_fault_v_o, 0);
    cyc(); fill_v_i = 0; fill_fault_i = 0;

    // PTW stalls four cycles: request held, buffer stays occupied
    walk_ready_i = 0;
    data_miss(1, 39'h5_5555_5000); cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4 walk_v held", walk_v_o, 1);
      chk("t4 vaddr held", walk_vaddr_o, 39'h5_5555_5000);
      chk("t4 buffer held", data_ready_o, 0);
      cyc();
    end
    walk_ready_i = 1;
    complete(0, 28'h6);

    // Flush while waiting: the fill is swallowed, next miss still serviced
    instr_miss(39'h66000); cyc(); cyc();
    flush_i = 1; cyc(); flush_i = 0;
    fill_v_i = 1;
    @(negedge clk);
    chk("t5 no itlb_fill", itlb_fill_v_o, 0);
    chk("t5 no instr_pf", instr_page_fault_v_o, 0);
    chk("t5 instr_ready", instr_ready_o, 1);
    cyc(); fill_v_i = 0;
    @(negedge clk);
    chk("t5 idle", busy_o, 0);
    instr_miss(39'h77000); cyc();
    @(negedge clk);
    chk("t5 next walk_v", walk_v_o, 1);
    complete(0, 28'h7);

    // Reset mid-walk, then a stray fill
    instr_miss(39'h88000); cyc(); cyc();
    reset_i = 1; cyc(); reset_i = 0;
    fill_v_i = 1;
    @(negedge clk);
    chk("t6 no itlb_fill", itlb_fill_v_o, 0);
    chk("t6 busy", busy_o, 0);
    chk("t6 walk_v", walk_v_o, 0);
    cyc(); fill_v_i = 0;

    // Randomized traffic, every output checked by the model each cycle
    for (int i = 0; i < 4000; i++) begin
      reset_i        = ($urandom_range(0, 199) == 0);
      flush_i        = ($urandom_range(0, 24) == 0);
      instr_miss_v_i = ($urandom_range(0, 3) == 0);
      instr_vaddr_i  = VW'({$urandom, $urandom});
      data_miss_v_i  = ($urandom_range(0, 3) == 0);
      data_store_i   = 1'($urandom);
      data_vaddr_i   = VW'({$urandom, $urandom});
      walk_ready_i   = ($urandom_range(0, 9) < 6);
      fill_v_i       = ($urandom_range(0, 5) == 0);
      fill_fault_i   = ($urandom_range(0, 3) == 0);
      fill_ptag_i    = PW'($urandom);
      cyc();
    end
    idle_inputs(); reset_i = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
